// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: default data width and opcode encodings.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

endpackage : alu_pkg

// File: rtl/alu16_datapath.sv
// Purely combinational ALU datapath: computes the next result and its status flags.
module alu16_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] next_w,
  output logic             next_zero,
  output logic             next_neg
);

  // cin widened once so the add/sub paths stay width-matched.
  logic [WIDTH-1:0] cin_ext;
  assign cin_ext = {{(WIDTH-1){1'b0}}, cin};

  // Select the operation result; carry-out and overflow fall off the top.
  always_comb begin
    // NOTE: assigning a default before the case guarantees no latch is inferred
    // even if a branch is later added without an assignment.
    next_w = '0;
    case (opc)
      OP_ADD: next_w = a + b + cin_ext;
      OP_SUB: next_w = a - b - cin_ext;
      OP_AND: next_w = a & b;
      OP_OR:  next_w = a | b;
      OP_XOR: next_w = a ^ b;
      OP_NOT: next_w = ~a;
      OP_SHL: next_w = {a[WIDTH-2:0], cin};
      OP_SHR: next_w = {cin, a[WIDTH-1:1]};
      default: next_w = '0;
    endcase
  end

  // Flags derive from the same next result so they can never disagree with w.
  assign next_zero = (next_w == '0);
  assign next_neg  = next_w[WIDTH-1];

endmodule : alu16_datapath

// File: rtl/alu16_core.sv
// Execute-stage ALU: combinational datapath followed by one output register stage.
module alu16_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] w,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] w_d, w_q;
  logic             zero_d, zero_q;
  logic             neg_d, neg_q;

  alu16_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a         (a),
    .b         (b),
    .cin       (cin),
    .opc       (opc),
    .next_w    (w_d),
    .next_zero (zero_d),
    .next_neg  (neg_d)
  );

  // Register result and flags together; synchronous reset wins over any opcode.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // so ordering of statements inside clocked blocks does not matter.
    if (rst) begin
      w_q    <= '0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      w_q    <= w_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign w    = w_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule : alu16_core

// File: tb/tb_alu16_core.sv
// Directed self-checking bench for alu16_core: reset, wrap cases, logic ops,
// shifts, back-to-back opcode pipelining and reference-model random vectors.
module tb_alu16_core;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   opc;
  logic [W-1:0] w;
  logic         zero;
  logic         neg;

  int n_checks = 0;
  int n_fail   = 0;

  alu16_core #(
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .opc  (opc),
    .w    (w),
    .zero (zero),
    .neg  (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare w and both flags against an expected result.
  task automatic expect_out(input string tag, input logic [W-1:0] exp_w);
    check({tag, ".w"},    32'(w),    32'(exp_w));
    check({tag, ".zero"}, 32'(zero), 32'(exp_w == '0));
    check({tag, ".neg"},  32'(neg),  32'(exp_w[W-1]));
  endtask

  // Drive inputs, clock one edge, then sample 1 ns after the edge.
  task automatic apply(input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic c);
    opc = o; a = av; b = bv; cin = c;
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the random section.
  function automatic logic [W-1:0] ref_alu(input logic [2:0] o, input logic [W-1:0] av,
                                           input logic [W-1:0] bv, input logic c);
    logic [W:0] t;
    case (o)
      3'd0: t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c};
      3'd1: t = {1'b0, av} + {1'b0, ~bv} + {{W{1'b0}}, ~c};
      3'd2: t = {1'b0, av & bv};
      3'd3: t = {1'b0, av | bv};
      3'd4: t = {1'b0, av ^ bv};
      3'd5: t = {1'b0, ~av};
      3'd6: t = {av, c};
      default: t = {1'b0, c, av[W-1:1]};
    endcase
    return t[W-1:0];
  endfunction

  logic [W-1:0] pipe_exp [8];
  logic [W-1:0] ra, rb;
  logic         rc;

  initial begin
    pipe_exp = '{16'h0008, 16'h0002, 16'h0001, 16'h0007,
                 16'h0006, 16'hFFFA, 16'h000A, 16'h0002};

    // Reset held for two edges with a live ADD on the inputs.
    rst = 1'b1;
    apply(3'd0, 16'h1234, 16'h5678, 1'b0);
    apply(3'd0, 16'h1234, 16'h5678, 1'b0);
    expect_out("reset", 16'h0000);
    rst = 1'b0;
    apply(3'd0, 16'h1234, 16'h5678, 1'b0);
    expect_out("first_after_reset", 16'h68AC);

    // Wrap-around cases.
    apply(3'd0, 16'hFFFF, 16'h0001, 1'b0);
    expect_out("add_wrap", 16'h0000);
    apply(3'd1, 16'h0000, 16'h0001, 1'b1);
    expect_out("sub_wrap_cin", 16'hFFFE);
    apply(3'd1, 16'h0000, 16'h0001, 1'b0);
    expect_out("sub_wrap", 16'hFFFF);
    apply(3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_out("add_cin_ffff", 16'hFFFF);

    // Logic ops, with cin both ways to show it is ignored.
    for (int c = 0; c < 2; c++) begin
      apply(3'd2, 16'hF0F0, 16'hFF00, c[0]);
      expect_out($sformatf("and_c%0d", c), 16'hF000);
      apply(3'd3, 16'hF0F0, 16'hFF00, c[0]);
      expect_out($sformatf("or_c%0d", c), 16'hFFF0);
      apply(3'd4, 16'hF0F0, 16'hFF00, c[0]);
      expect_out($sformatf("xor_c%0d", c), 16'h0FF0);
      apply(3'd5, 16'hF0F0, 16'hFF00, c[0]);
      expect_out($sformatf("not_c%0d", c), 16'h0F0F);
    end

    // Shifts.
    apply(3'd6, 16'h8001, 16'h0000, 1'b1);
    expect_out("shl_cin1", 16'h0003);
    apply(3'd7, 16'h8001, 16'h0000, 1'b1);
    expect_out("shr_cin1", 16'hC000);
    apply(3'd7, 16'h8001, 16'h0000, 1'b0);
    expect_out("shr_cin0", 16'h4000);

    // Opcode changes every cycle; each result lands exactly one edge later.
    for (int k = 0; k < 8; k++) begin
      apply(3'(k), 16'h0005, 16'h0003, 1'b0);
      expect_out($sformatf("pipe_op%0d", k), pipe_exp[k]);
    end

    // Random vectors per opcode against the reference, with a mid-run reset pulse.
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 10; i++) begin
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        if (o == 4 && i == 5) begin
          rst = 1'b1;
          apply(3'(o), ra, rb, rc);
          expect_out("mid_reset", 16'h0000);
          rst = 1'b0;
        end
        apply(3'(o), ra, rb, rc);
        expect_out($sformatf("rand_op%0d_%0d", o, i), ref_alu(3'(o), ra, rb, rc));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu16_core
